// File: rtl/sprite_pkg.sv
// sprite_pkg: shared types for the board-sprite tile RAMs.
//   sprite_e     - which built-in image a tile RAM powers up with
//   TILE_W       - sprite edge length in pixels; TILE_WORDS = TILE_W*TILE_W
//   pixel_t      - 32-bit pixel {rsvd, b, g, r}, rsvd always 0 in built-in images
//   sprite_word  - built-in image generator, word at row r / column c
package sprite_pkg;
  localparam int TILE_W     = 50;
  localparam int TILE_WORDS = TILE_W * TILE_W;

  typedef enum logic [2:0] {
    SPR_BLUECITY,
    SPR_BLUECROWN,
    SPR_MOUNTAIN,
    SPR_REDCITY,
    SPR_REDCROWN,
    SPR_NEUTRALCITY
  } sprite_e;

  typedef struct packed {
    logic [7:0] rsvd;
    logic [7:0] b;
    logic [7:0] g;
    logic [7:0] r;
  } pixel_t;

  function automatic logic [31:0] sprite_word(sprite_e spr, int r, int c);
    pixel_t px;
    px = '0;
    case (spr)
      SPR_BLUECITY: px.b = 8'hFF;
      SPR_BLUECROWN: begin
        px.b = 8'hFF;
        // white 10x10 centre block
        if (r >= 20 && r <= 29 && c >= 20 && c <= 29) begin
          px.g = 8'hFF;
          px.r = 8'hFF;
        end
      end
      SPR_MOUNTAIN: begin
        px.r = 8'h80;
        px.g = 8'h80;
        px.b = 8'h80;
      end
      default: px = '0;
    endcase
    return px;
  endfunction
endpackage

// File: rtl/sprite_tile_ram_if.sv
// sprite_tile_ram_if: RAM access bus.
//   address - word address (row*50 + col)
//   data    - write data
//   wren    - write enable
//   q       - read data
// master = requester (display path / updater), slave = the RAM.
interface sprite_tile_ram_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data;
  logic              wren;
  logic [DATA_W-1:0] q;

  modport master (output address, output data, output wren, input q);
  modport slave  (input address, input data, input wren, output q);
endinterface

// File: rtl/sprite_tile_ram_core.sv
// sprite_tile_ram_core: plain single-port word array.
//   clock - write/read clock
//   we    - write enable (caller guarantees addr is in range)
//   addr  - word address, always < DEPTH
//   wdata - write data
//   rd_q  - registered read data; returns the pre-write word on a
//           same-address read-during-write
// The array has no reset; it powers up with the built-in sprite image.
module sprite_tile_ram_core
  import sprite_pkg::*;
#(
  parameter int      DATA_W    = 32,
  parameter int      DEPTH     = TILE_WORDS,
  parameter int      AW        = 12,
  parameter sprite_e SPRITE    = SPR_BLUECITY,
  parameter string   INIT_FILE = ""
) (
  input  logic              clock,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rd_q
);
  typedef logic [DATA_W-1:0] img_t [DEPTH];

  function automatic img_t build_image();
    img_t img;
    for (int i = 0; i < DEPTH; i++)
      img[i] = (i < TILE_WORDS) ? DATA_W'(sprite_word(SPRITE, i / TILE_W, i % TILE_W)) : '0;
    return img;
  endfunction

  img_t mem = build_image();

  // Non-blocking read of the same word being written yields the old data.
  always_ff @(posedge clock) begin
    if (we) mem[addr] <= wdata;
    rd_q <= mem[addr];
  end
endmodule

// File: rtl/sprite_tile_ram.sv
// sprite_tile_ram: 50x50 sprite tile RAM, one instance per board sprite.
//   clock - pixel clock
//   reset - asynchronous, active-low; clears the read path, not the array
//   bus   - sprite_tile_ram_if slave (address, data, wren, q)
// Adds the range check around the core: out-of-range reads return 0 and
// out-of-range writes are dropped (no wrap). Writes are ignored in reset.
// Build option SPRITE_TILE_RAM_OUTREG_EN adds an output register
// (read latency 2 instead of 1).
module sprite_tile_ram
  import sprite_pkg::*;
#(
  parameter int      ADDR_W    = 16,
  parameter int      DATA_W    = 32,
  parameter int      DEPTH     = TILE_WORDS,
  parameter sprite_e SPRITE    = SPR_BLUECITY,
  parameter string   INIT_FILE = ""
) (
  input logic              clock,
  input logic              reset,
  sprite_tile_ram_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  logic              in_range;
  logic              core_we;
  logic [AW-1:0]     core_addr;
  logic [DATA_W-1:0] core_q;
  logic              rd_vld;
  logic [DATA_W-1:0] rd_data;

  // Compare on the full address so high bits can never alias into the array.
  assign in_range  = (bus.address < ADDR_W'(DEPTH));
  assign core_addr = in_range ? bus.address[AW-1:0] : '0;
  assign core_we   = bus.wren & in_range & reset;

  sprite_tile_ram_core #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .AW        (AW),
    .SPRITE    (SPRITE),
    .INIT_FILE (INIT_FILE)
  ) u_core (
    .clock (clock),
    .we    (core_we),
    .addr  (core_addr),
    .wdata (bus.data),
    .rd_q  (core_q)
  );

  // Range flag travels with the read; it doubles as the reset of stage 1,
  // since the core's read register itself is not reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rd_vld <= 1'b0;
    else        rd_vld <= in_range;
  end

  assign rd_data = rd_vld ? core_q : '0;

`ifdef SPRITE_TILE_RAM_OUTREG_EN
  logic [DATA_W-1:0] q_r;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) q_r <= '0;
    else        q_r <= rd_data;
  end

  assign bus.q = q_r;
`else
  assign bus.q = rd_data;
`endif
endmodule

// File: tb/tb_sprite_tile_ram.sv
module tb_sprite_tile_ram;
  import sprite_pkg::*;

`ifdef SPRITE_TILE_RAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  localparam logic [31:0] BLUE  = 32'h00FF0000;
  localparam logic [31:0] WHITE = 32'h00FFFFFF;
  localparam logic [31:0] GREY  = 32'h00808080;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  sprite_tile_ram_if #(.ADDR_W(16), .DATA_W(32)) bus_c ();
  sprite_tile_ram_if #(.ADDR_W(16), .DATA_W(32)) bus_k ();
  sprite_tile_ram_if #(.ADDR_W(16), .DATA_W(32)) bus_m ();

  sprite_tile_ram #(.SPRITE(SPR_BLUECITY))  u_city  (.clock(clock), .reset(reset), .bus(bus_c));
  sprite_tile_ram #(.SPRITE(SPR_BLUECROWN)) u_crown (.clock(clock), .reset(reset), .bus(bus_k));
  sprite_tile_ram #(.SPRITE(SPR_MOUNTAIN))  u_mtn   (.clock(clock), .reset(reset), .bus(bus_m));

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int          dut;   // 0 city, 1 crown, 2 mountain
    logic [15:0] addr;
    logic        wren;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    int          dut;
    logic [31:0] exp;
    int          due;
    int          tag;
  } sb_t;

  sb_t sbq[$];

  task automatic check(string nm, int tag, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: got %h expected %h (cycle %0d)", nm, tag, act, exp, cyc);
  endtask

  function automatic logic [31:0] getq(int d);
    case (d)
      0:       return bus_c.q;
      1:       return bus_k.q;
      default: return bus_m.q;
    endcase
  endfunction

  task automatic idle_all();
    bus_c.address = '0; bus_c.wren = 1'b0; bus_c.data = '0;
    bus_k.address = '0; bus_k.wren = 1'b0; bus_k.data = '0;
    bus_m.address = '0; bus_m.wren = 1'b0; bus_m.data = '0;
  endtask

  task automatic set_bus(int d, logic [15:0] a, logic w, logic [31:0] dat);
    idle_all();
    case (d)
      0:       begin bus_c.address = a; bus_c.wren = w; bus_c.data = dat; end
      1:       begin bus_k.address = a; bus_k.wren = w; bus_k.data = dat; end
      default: begin bus_m.address = a; bus_m.wren = w; bus_m.data = dat; end
    endcase
  endtask

  // Drive one access on a negedge; its result is due LAT posedges later.
  task automatic drive(int d, logic [15:0] a, logic w, logic [31:0] dat, logic [31:0] e, int tag);
    @(negedge clock);
    set_bus(d, a, w, dat);
    sbq.push_back('{d, e, cyc + LAT, tag});
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge clock);
    idle_all();
    while (sbq.size() > 0 && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (sbq.size() > 0) begin
      check("drain_timeout", sbq.size(), 32'd1, 32'd0);
      sbq.delete();
    end
  endtask

  // Scoreboard: compare each result on the negedge it falls due.
  always @(negedge clock) begin
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      sb_t e;
      e = sbq.pop_front();
      if (e.due < cyc) check("late", e.tag, 32'd1, 32'd0);
      else             check("read", e.tag, getq(e.dut), e.exp);
    end
  end

  vec_t vecs[29];

  initial begin
    vecs[0]  = '{0, 16'd0,     1'b0, 32'h0,        BLUE};
    vecs[1]  = '{0, 16'd2499,  1'b0, 32'h0,        BLUE};
    vecs[2]  = '{0, 16'd2500,  1'b0, 32'h0,        32'h0};
    vecs[3]  = '{1, 16'd1045,  1'b0, 32'h0,        BLUE};
    vecs[4]  = '{1, 16'd1245,  1'b0, 32'h0,        BLUE};
    vecs[5]  = '{1, 16'd1225,  1'b0, 32'h0,        WHITE};
    vecs[6]  = '{1, 16'd1020,  1'b0, 32'h0,        WHITE};
    vecs[7]  = '{1, 16'd1019,  1'b0, 32'h0,        BLUE};
    vecs[8]  = '{1, 16'd1479,  1'b0, 32'h0,        WHITE};
    vecs[9]  = '{1, 16'd1480,  1'b0, 32'h0,        BLUE};
    vecs[10] = '{1, 16'd970,   1'b0, 32'h0,        BLUE};
    vecs[11] = '{2, 16'd2499,  1'b0, 32'h0,        GREY};
    vecs[12] = '{2, 16'd2500,  1'b0, 32'h0,        32'h0};
    vecs[13] = '{2, 16'hFFFF,  1'b0, 32'h0,        32'h0};
    vecs[14] = '{2, 16'd0,     1'b0, 32'h0,        GREY};
    vecs[15] = '{0, 16'd7,     1'b1, 32'h00123456, BLUE};
    vecs[16] = '{0, 16'd7,     1'b0, 32'h0,        32'h00123456};
    vecs[17] = '{0, 16'd3000,  1'b1, 32'hAABBCCDD, 32'h0};
    vecs[18] = '{0, 16'd3000,  1'b0, 32'h0,        32'h0};
    vecs[19] = '{0, 16'd500,   1'b0, 32'h0,        BLUE};
    vecs[20] = '{0, 16'd4103,  1'b0, 32'h0,        32'h0};
    vecs[21] = '{0, 16'd8,     1'b1, 32'hFF000001, BLUE};
    vecs[22] = '{0, 16'd8,     1'b0, 32'h0,        32'hFF000001};
    vecs[23] = '{2, 16'd2499,  1'b1, 32'h00ABCDEF, GREY};
    vecs[24] = '{2, 16'd2499,  1'b0, 32'h0,        32'h00ABCDEF};
    vecs[25] = '{2, 16'd2500,  1'b0, 32'h0,        32'h0};
    vecs[26] = '{2, 16'd1,     1'b0, 32'h0,        GREY};
    vecs[27] = '{2, 16'd3000,  1'b0, 32'h0,        32'h0};
    vecs[28] = '{0, 16'd7,     1'b0, 32'h0,        32'h00123456};

    // Reset held: reads requested, outputs must stay 0.
    idle_all();
    set_bus(0, 16'd0, 1'b0, 32'h0);
    repeat (2) begin
      @(posedge clock); #1;
      check("rst_city",  0, bus_c.q, 32'h0);
      check("rst_crown", 0, bus_k.q, 32'h0);
      check("rst_mtn",   0, bus_m.q, 32'h0);
    end
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 29; i++)
      drive(vecs[i].dut, vecs[i].addr, vecs[i].wren, vecs[i].data, vecs[i].exp, i);
    drain();

    // Mid-burst async reset on the city RAM.
    drive(0, 16'd1, 1'b0, 32'h0, BLUE, 100);
    drive(0, 16'd2, 1'b0, 32'h0, BLUE, 101);
    drive(0, 16'd3, 1'b0, 32'h0, BLUE, 102);
    @(posedge clock); #2;
    reset = 1'b0;
    #1;
    sbq.delete();
    check("async_rst_city", 1, bus_c.q, 32'h0);
    check("async_rst_mtn",  1, bus_m.q, 32'h0);
    // Write attempted while in reset must be ignored.
    @(negedge clock);
    set_bus(0, 16'd10, 1'b1, 32'hDEADBEEF);
    @(posedge clock); #1;
    check("rst_hold_city", 2, bus_c.q, 32'h0);
    @(negedge clock);
    idle_all();
    reset = 1'b1;
    drive(0, 16'd10, 1'b0, 32'h0, BLUE,         110);
    drive(0, 16'd7,  1'b0, 32'h0, 32'h00123456, 111);
    drive(1, 16'd1225, 1'b0, 32'h0, WHITE,      112);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
